// File: rtl/matrix_core_scratchpad_if.sv
// Request/response bus between the core sequencer (master) and the matrix-core scratchpad (slave).
interface matrix_core_scratchpad_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
);
    logic                  req_vld;
    logic                  req_rdy;
    logic [1:0]            req_bank;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ACC_WIDTH-1:0]  req_wdata;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [ACC_WIDTH-1:0]  rsp_data;
    logic                  rsp_err;

    modport master (
        output req_vld, req_bank, req_op, req_addr, req_wdata, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_data, rsp_err
    );

    modport slave (
        input  req_vld, req_bank, req_op, req_addr, req_wdata, rsp_rdy,
        output req_rdy, rsp_vld, rsp_data, rsp_err
    );
endinterface

// File: rtl/matrix_core_scratchpad.sv
// Banked W/X/ACC scratchpad: single-issue request port, in-order 2-deep response buffer,
// accumulate on ACC and a one-entry-per-cycle bank clear sequencer.
module matrix_core_scratchpad_bank #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

module matrix_core_scratchpad #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int MAT_DIM    = 4,
    parameter int X_DEPTH    = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    matrix_core_scratchpad_if.slave bus
);
    localparam int W_DEPTH = MAT_DIM * MAT_DIM;
    localparam int W_AW    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int X_AW    = (X_DEPTH > 1) ? $clog2(X_DEPTH) : 1;
    localparam int C_DEPTH = (W_DEPTH > X_DEPTH) ? W_DEPTH : X_DEPTH;
    localparam int C_AW    = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

    localparam logic [1:0] BANK_W   = 2'd0;
    localparam logic [1:0] BANK_X   = 2'd1;
    localparam logic [1:0] BANK_ACC = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ADD   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef struct packed {
        logic [1:0]            bank;
        logic [1:0]            op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ACC_WIDTH-1:0]  wdata;
    } req_t;

    typedef struct packed {
        logic                 err;
        logic [ACC_WIDTH-1:0] data;
    } rsp_t;

    function automatic logic [C_AW-1:0] last_idx(input logic [1:0] b);
        return (b == BANK_W) ? C_AW'(W_DEPTH - 1) : C_AW'(X_DEPTH - 1);
    endfunction

    logic [1:0]      state_q, state_d;
    logic [C_AW-1:0] clr_idx_q, clr_idx_d;
    logic [1:0]      clr_bank_q, clr_bank_d;
    logic [1:0]      cnt_q, cnt_d;
    rsp_t            buf_q [2];
    rsp_t            buf_d [2];

    req_t            req;
    logic            req_rdy, accept, addr_ok, req_err, req_wr, clearing;
    logic            push, pop;
    rsp_t            push_rsp;
    logic [C_AW-1:0] wr_idx;
    logic            zero_wr;
    logic            we_w, we_x, we_acc;
    logic [DATA_WIDTH-1:0] w_rdata, x_rdata, wx_wdata;
    logic [ACC_WIDTH-1:0]  acc_rdata, acc_wdata, rd_data;

    assign req      = {bus.req_bank, bus.req_op, bus.req_addr, bus.req_wdata};
    assign req_rdy  = (state_q == ST_IDLE) && (cnt_q != 2'd2);
    assign accept   = bus.req_vld && req_rdy;
    assign clearing = (state_q == ST_CLEAR);

    always_comb begin
        case (req.bank)
            BANK_W:           addr_ok = req.addr < ADDR_WIDTH'(W_DEPTH);
            BANK_X, BANK_ACC: addr_ok = req.addr < ADDR_WIDTH'(X_DEPTH);
            default:          addr_ok = 1'b0;
        endcase
    end

    // CLEAR only validates the bank; its address field is ignored.
    assign req_err = (req.bank == 2'd3)
                  || ((req.op != OP_CLEAR) && !addr_ok)
                  || ((req.op == OP_ADD) && (req.bank != BANK_ACC));
    assign req_wr  = accept && !req_err && (req.op != OP_READ);

    // Banks share one write index: the clear sweep while busy, else the request (CLEAR starts at 0).
    assign wr_idx   = clearing ? clr_idx_q
                    : (req.op == OP_CLEAR) ? '0 : req.addr[C_AW-1:0];
    assign zero_wr  = clearing || (req.op == OP_CLEAR);
    assign wx_wdata = zero_wr ? '0 : req.wdata[DATA_WIDTH-1:0];
    assign acc_wdata = zero_wr ? '0
                     : (req.op == OP_ADD) ? acc_rdata + req.wdata : req.wdata;

    assign we_w   = clearing ? (clr_bank_q == BANK_W)   : (req_wr && req.bank == BANK_W);
    assign we_x   = clearing ? (clr_bank_q == BANK_X)   : (req_wr && req.bank == BANK_X);
    assign we_acc = clearing ? (clr_bank_q == BANK_ACC) : (req_wr && req.bank == BANK_ACC);

    matrix_core_scratchpad_bank #(.DEPTH(W_DEPTH), .WIDTH(DATA_WIDTH)) u_w (
        .clk_i(clk_i), .we_i(we_w), .waddr_i(wr_idx[W_AW-1:0]), .wdata_i(wx_wdata),
        .raddr_i(req.addr[W_AW-1:0]), .rdata_o(w_rdata)
    );

    matrix_core_scratchpad_bank #(.DEPTH(X_DEPTH), .WIDTH(DATA_WIDTH)) u_x (
        .clk_i(clk_i), .we_i(we_x), .waddr_i(wr_idx[X_AW-1:0]), .wdata_i(wx_wdata),
        .raddr_i(req.addr[X_AW-1:0]), .rdata_o(x_rdata)
    );

    matrix_core_scratchpad_bank #(.DEPTH(X_DEPTH), .WIDTH(ACC_WIDTH)) u_acc (
        .clk_i(clk_i), .we_i(we_acc), .waddr_i(wr_idx[X_AW-1:0]), .wdata_i(acc_wdata),
        .raddr_i(req.addr[X_AW-1:0]), .rdata_o(acc_rdata)
    );

    always_comb begin
        case (req.bank)
            BANK_W:   rd_data = ACC_WIDTH'(w_rdata);
            BANK_X:   rd_data = ACC_WIDTH'(x_rdata);
            BANK_ACC: rd_data = acc_rdata;
            default:  rd_data = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        clr_bank_d = clr_bank_q;
        push       = 1'b0;
        push_rsp   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    push_rsp.err  = req_err;
                    push_rsp.data = ((req.op == OP_READ) && !req_err) ? rd_data : '0;
                    if ((req.op == OP_CLEAR) && !req_err && (last_idx(req.bank) != '0)) begin
                        state_d    = ST_CLEAR;
                        clr_bank_d = req.bank;
                        clr_idx_d  = C_AW'(1);
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + C_AW'(1);
                if (clr_idx_q == last_idx(clr_bank_q)) begin
                    if (cnt_q != 2'd2) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cnt_q != 2'd2) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Head-at-0 shift buffer; vacated slots are zeroed so an empty buffer presents data=0/err=0.
    assign pop = (cnt_q != 2'd0) && bus.rsp_rdy;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = '0;
            cnt_d    = cnt_q - 2'd1;
        end
        if (push) begin
            buf_d[cnt_d[0]] = push_rsp;
            cnt_d           = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            clr_idx_q  <= '0;
            clr_bank_q <= '0;
            cnt_q      <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            clr_bank_q <= clr_bank_d;
            cnt_q      <= cnt_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

    assign bus.req_rdy  = req_rdy;
    assign bus.rsp_vld  = (cnt_q != 2'd0);
    assign bus.rsp_data = buf_q[0].data;
    assign bus.rsp_err  = buf_q[0].err;
endmodule

// File: tb/tb_matrix_core_scratchpad.sv
// Randomized bench for matrix_core_scratchpad with an in-order response scoreboard
// fed by an array-level model of the three banks.
module tb_matrix_core_scratchpad;
    localparam int DEPTH = 16;
    localparam logic [1:0] W = 2'd0, X = 2'd1, ACC = 2'd2, BAD = 2'd3;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, ADD = 2'd2, CLR = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_core_scratchpad_if #(.ADDR_WIDTH(8), .ACC_WIDTH(32)) bus ();

    matrix_core_scratchpad dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          is_clr;
    } exp_t;

    logic [31:0] m_mem [3][DEPTH];
    exp_t        q [$];
    int          nvec = 0;
    int          nerr = 0;
    bit          chk_en = 0;
    bit          clr_pend = 0;
    bit          prev_stall = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Whole-bank semantics: a CLEAR zeroes its bank at once, since nothing else is accepted meanwhile.
    task automatic apply(input logic [1:0] b, input logic [1:0] op, input logic [7:0] a,
                         input logic [31:0] d);
        exp_t e;
        e = '{err: 1'b0, data: 32'd0, is_clr: 1'b0};
        if (op == CLR) begin
            if (b == BAD) e.err = 1'b1;
            else begin
                for (int i = 0; i < DEPTH; i++) m_mem[b][i] = 32'd0;
                e.is_clr = 1'b1;
                clr_pend = 1'b1;
            end
        end else if (b == BAD || a >= DEPTH || (op == ADD && b != ACC)) begin
            e.err = 1'b1;
        end else begin
            case (op)
                RD:      e.data = m_mem[b][a];
                WR:      m_mem[b][a] = (b == ACC) ? d : {24'd0, d[7:0]};
                default: m_mem[b][a] = m_mem[b][a] + d;
            endcase
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            clr_pend   = 0;
            prev_stall = 0;
        end else if (chk_en) begin
            if (!clr_pend) begin
                chk("rsp_vld", {31'd0, bus.rsp_vld}, {31'd0, q.size() != 0});
                chk("req_rdy", {31'd0, bus.req_rdy}, {31'd0, q.size() < 2});
            end
            if (prev_stall) chk("hold_vld", {31'd0, bus.rsp_vld}, 32'd1);
            if (bus.rsp_vld && bus.rsp_rdy) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rsp_extra: got data %h with no expected response", bus.rsp_data);
                end else begin
                    e = q.pop_front();
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                    if (e.is_clr) clr_pend = 0;
                end
            end
            prev_stall = bus.rsp_vld && !bus.rsp_rdy;
            if (bus.req_vld && bus.req_rdy)
                apply(bus.req_bank, bus.req_op, bus.req_addr, bus.req_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] b, input logic [1:0] op, input logic [7:0] a,
                         input logic [31:0] d, input bit rnd);
        int g = 0;
        bus.req_vld   = 1'b1;
        bus.req_bank  = b;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_rdy && g < 200) begin
            if (rnd) bus.rsp_rdy = ($urandom_range(0, 3) != 0);
            tick();
            g++;
        end
        if (!bus.req_rdy) begin
            nvec++;
            nerr++;
            $display("FAIL issue_timeout: got req_rdy 0 expected 1 within 200 cycles");
        end else begin
            tick();
        end
        bus.req_vld = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        bus.rsp_rdy = 1'b1;
        while ((bus.rsp_vld || !bus.req_rdy) && g < 100) begin
            tick();
            g++;
        end
        chk("drain_empty", {31'd0, bus.rsp_vld}, 32'd0);
    endtask

    initial begin
        int cnt;
        bus.req_vld   = 1'b0;
        bus.req_bank  = 2'd0;
        bus.req_op    = 2'd0;
        bus.req_addr  = 8'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_rdy   = 1'b1;
        repeat (3) tick();
        chk("rst_rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        rst = 1'b0;
        chk("rst_req_rdy", {31'd0, bus.req_rdy}, 32'd1);
        chk_en = 1;

        for (int b = 0; b < 3; b++)
            for (int a = 0; a < DEPTH; a++) issue(b[1:0], WR, a[7:0], $urandom, 0);

        // 1: write then read W[5], latency 1
        issue(W, WR, 8'd5, 32'h0000_00A5, 0);
        chk("t1_wr_vld", {31'd0, bus.rsp_vld}, 32'd1);
        chk("t1_wr_data", bus.rsp_data, 32'd0);
        issue(W, RD, 8'd5, 32'd0, 0);
        chk("t1_rd_data", bus.rsp_data, 32'h0000_00A5);
        chk("t1_rd_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("t1_model", m_mem[0][5], 32'h0000_00A5);

        // 2: accumulate wraps
        issue(ACC, WR, 8'd3, 32'hFFFF_FFFF, 0);
        issue(ACC, ADD, 8'd3, 32'd2, 0);
        issue(ACC, RD, 8'd3, 32'd0, 0);
        chk("t2_rd_data", bus.rsp_data, 32'h0000_0001);
        chk("t2_rd_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("t2_model", m_mem[2][3], 32'h0000_0001);

        // 3: backpressure with a full buffer
        drain();
        bus.rsp_rdy = 1'b0;
        issue(X, RD, 8'd0, 32'd0, 0);
        issue(X, RD, 8'd1, 32'd0, 0);
        bus.req_vld = 1'b1;
        bus.req_addr = 8'd2;
        repeat (3) tick();
        chk("t3_rdy_full", {31'd0, bus.req_rdy}, 32'd0);
        chk("t3_head", bus.rsp_data, m_mem[1][0]);
        bus.rsp_rdy = 1'b1;
        issue(X, RD, 8'd2, 32'd0, 0);
        drain();

        // 4: clear X
        for (int a = 0; a < DEPTH; a++) issue(X, WR, a[7:0], $urandom_range(1, 255), 0);
        drain();
        issue(X, CLR, 8'd9, 32'd0, 0);
        cnt = 0;
        while (!bus.req_rdy && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("t4_busy_cycles", cnt, DEPTH - 1);
        chk("t4_done_vld", {31'd0, bus.rsp_vld}, 32'd1);
        chk("t4_done_data", bus.rsp_data, 32'd0);
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < DEPTH; a++) issue(b[1:0], RD, a[7:0], 32'd0, 0);
        drain();

        // 5: rejected requests
        issue(BAD, RD, 8'd0, 32'd0, 0);
        chk("t5_bank3_err", {31'd0, bus.rsp_err}, 32'd1);
        chk("t5_bank3_data", bus.rsp_data, 32'd0);
        issue(W, RD, 8'd16, 32'd0, 0);
        chk("t5_oob_err", {31'd0, bus.rsp_err}, 32'd1);
        issue(X, ADD, 8'd0, 32'd7, 0);
        chk("t5_addx_err", {31'd0, bus.rsp_err}, 32'd1);
        issue(X, RD, 8'd0, 32'd0, 0);
        chk("t5_x0_data", bus.rsp_data, 32'd0);
        drain();

        // 6: reset mid-clear with a buffered response
        bus.rsp_rdy = 1'b0;
        issue(W, RD, 8'd0, 32'd0, 0);
        issue(ACC, CLR, 8'd0, 32'd0, 0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        chk("t6_req_rdy", {31'd0, bus.req_rdy}, 32'd1);
        bus.rsp_rdy = 1'b1;
        for (int a = 0; a < DEPTH; a++) issue(ACC, WR, a[7:0], $urandom, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [1:0] b, op;
            logic [7:0] a;
            if ($urandom_range(0, 99) < 10) begin
                bus.rsp_rdy = ($urandom_range(0, 3) != 0);
                tick();
            end else begin
                b  = ($urandom_range(0, 99) < 5) ? BAD : 2'($urandom_range(0, 2));
                op = ($urandom_range(0, 99) < 3) ? CLR : 2'($urandom_range(0, 2));
                a  = ($urandom_range(0, 99) < 10) ? 8'($urandom_range(16, 255))
                                                  : 8'($urandom_range(0, 15));
                bus.rsp_rdy = ($urandom_range(0, 3) != 0);
                issue(b, op, a, $urandom, 1);
            end
        end
        drain();
        repeat (2) tick();
        chk("final_queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
